// File: rtl/packed_lane_sum.sv
// packed_lane_sum
// Frame-level reduction of packed lane words. Each accepted beat of
// LANES lanes of W bits is folded into a modular lane sum and OR/AND/XOR
// bit reductions; after BEATS beats the frame result is held on the
// output until the sink takes it.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   flush      abandon the current frame (ignored while a result is held)
//   in_valid   beat offered
//   in_ready   block accepts a beat this cycle (registered, state only)
//   in_data    packed beat, lane k at [k*W+W-1 : k*W]
//   out_valid  frame result held
//   out_ready  sink takes the result
//   out_sum    sum of all lanes of all beats, modulo 2^W
//   out_or     OR of every bit of the frame
//   out_and    AND of every bit of the frame
//   out_xor    XOR of every bit of the frame
//   out_frames completed-frame handshake counter (only with
//              PACKED_LANE_SUM_FRAMES_EN defined)
//
// Build option: define PACKED_LANE_SUM_FRAMES_EN to add out_frames.

module packed_lane_sum #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned BEATS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_sum,
    output logic                 out_or,
    output logic                 out_and,
    output logic                 out_xor
`ifdef PACKED_LANE_SUM_FRAMES_EN
    ,
    output logic [15:0]          out_frames
`endif
);

    localparam int unsigned SUM_W = W + $clog2(LANES);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [W-1:0]     acc_sum;
    logic             acc_or;
    logic             acc_and;
    logic             acc_xor;
    logic [CNT_W-1:0] beat_cnt;

    logic [SUM_W-1:0] lane_sum;
    logic [W-1:0]     sum_next;
    logic             accept;
    logic             last_beat;
    logic             release_hold;
    logic             flush_accum;

    // Lane sum kept at full width; truncation happens only at the accumulate.
    always_comb begin
        lane_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + SUM_W'(in_data[k*W +: W]);
        end
        sum_next = acc_sum + lane_sum[W-1:0];
    end

    // Handshake qualifiers; flush wins over a beat offered in the same cycle.
    always_comb begin
        flush_accum  = (state == ACCUM) && flush;
        accept       = (state == ACCUM) && in_valid && !flush;
        last_beat    = (beat_cnt == CNT_W'(BEATS - 1));
        release_hold = (state == HOLD) && out_ready;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && last_beat) state_next = HOLD;
            HOLD:    if (out_ready)           state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    // Accumulators, result registers and registered handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_sum   <= '0;
            acc_or    <= 1'b0;
            acc_and   <= 1'b1;
            acc_xor   <= 1'b0;
            beat_cnt  <= '0;
            out_sum   <= '0;
            out_or    <= 1'b0;
            out_and   <= 1'b0;
            out_xor   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == ACCUM);
            out_valid <= (state_next == HOLD);
            if (flush_accum || release_hold) begin
                acc_sum  <= '0;
                acc_or   <= 1'b0;
                acc_and  <= 1'b1;
                acc_xor  <= 1'b0;
                beat_cnt <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    out_sum <= sum_next;
                    out_or  <= acc_or  | (|in_data);
                    out_and <= acc_and & (&in_data);
                    out_xor <= acc_xor ^ (^in_data);
                end else begin
                    acc_sum  <= sum_next;
                    acc_or   <= acc_or  | (|in_data);
                    acc_and  <= acc_and & (&in_data);
                    acc_xor  <= acc_xor ^ (^in_data);
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef PACKED_LANE_SUM_FRAMES_EN
    // Counts result handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)             out_frames <= 16'd0;
        else if (release_hold) out_frames <= out_frames + 16'd1;
    end
`endif

endmodule

// File: tb/tb_packed_lane_sum.sv
// Self-checking bench for packed_lane_sum at default parameters
// (LANES=4, W=8, BEATS=4): directed frame table, hold/flush/reset
// sequences and random frames against an arithmetic reference model.

module tb_packed_lane_sum;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sum;
    logic        out_or;
    logic        out_and;
    logic        out_xor;
`ifdef PACKED_LANE_SUM_FRAMES_EN
    logic [15:0] out_frames;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int n_frames   = 0;

    always #5 clk = ~clk;

    packed_lane_sum dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_or    (out_or),
        .out_and   (out_and),
        .out_xor   (out_xor)
`ifdef PACKED_LANE_SUM_FRAMES_EN
        ,
        .out_frames(out_frames)
`endif
    );

    typedef struct {
        string        name;
        logic [127:0] data;   // beat i at [i*32 +: 32]
        int           hold;   // cycles out_ready is held low in HOLD
        logic [7:0]   sum;
        logic         o;
        logic         a;
        logic         x;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sum of all 16 bytes mod 256, plus whole-frame bit reductions.
    function automatic void model(input logic [127:0] d, output logic [7:0] s,
                                  output logic o, output logic a, output logic x);
        int total = 0;
        for (int i = 0; i < 16; i++) total += int'(d[i*8 +: 8]);
        s = 8'(total % 256);
        o = (d != 128'd0);
        a = (d == {128{1'b1}});
        x = ($countones(d) % 2) == 1;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_frame(input vec_t v);
        out_ready = (v.hold == 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v.data[i*32 +: 32];
            wait_ready(v.name);
            tick();
            if (i < 3) check({v.name, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check({v.name, "_valid"},  32'(out_valid), 32'd1);
        check({v.name, "_ready0"}, 32'(in_ready),  32'd0);
        check({v.name, "_sum"},    32'(out_sum),   32'(v.sum));
        check({v.name, "_or"},     32'(out_or),    32'(v.o));
        check({v.name, "_and"},    32'(out_and),   32'(v.a));
        check({v.name, "_xor"},    32'(out_xor),   32'(v.x));
        for (int h = 1; h < v.hold; h++) begin
            tick();
            check({v.name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({v.name, "_hold_ready"}, 32'(in_ready),  32'd0);
            check({v.name, "_hold_sum"},   32'(out_sum),   32'(v.sum));
            check({v.name, "_hold_flags"}, 32'({out_or, out_and, out_xor}),
                  32'({v.o, v.a, v.x}));
        end
        out_ready = 1'b1;
        tick();
        n_frames++;
        check({v.name, "_ready_back"}, 32'(in_ready),  32'd1);
        check({v.name, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic send_beats(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            wait_ready("pre");
            tick();
        end
        in_valid = 1'b0;
    endtask

    vec_t tbl[5];
    vec_t v;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        tbl[0] = '{"basic", {4{32'h40100401}}, 0, 8'h54, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{"ones",  {4{32'hFFFFFFFF}}, 0, 8'hF0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{"zeros", 128'd0,            0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{"single", {96'd0, 32'h00000001}, 0, 8'h01, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{"hold5", {4{32'h01010101}}, 5, 8'h10, 1'b1, 1'b0, 1'b0};

        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_flags",     32'({out_or, out_and, out_xor}), 32'd0);
`ifdef PACKED_LANE_SUM_FRAMES_EN
        check("rst_frames", 32'(out_frames), 32'd0);
`endif

        foreach (tbl[i]) do_frame(tbl[i]);

        // Flush with a beat offered: both accepted beats and the flushed one are dropped.
        send_beats(2, 32'h01010101);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h01010101;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        v = '{"post_flush", {4{32'h01010101}}, 0, 8'h10, 1'b1, 1'b0, 1'b0};
        do_frame(v);

        // Flush while holding a result is ignored.
        out_ready = 1'b0;
        send_beats(4, 32'h00000003);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("hold_flush_valid", 32'(out_valid), 32'd1);
        check("hold_flush_sum",   32'(out_sum),   32'h0C);
        out_ready = 1'b1;
        tick();
        n_frames++;
        check("hold_flush_release", 32'(in_ready), 32'd1);

`ifdef PACKED_LANE_SUM_FRAMES_EN
        check("frames_count", 32'(out_frames), 32'(n_frames));
`endif

        // Reset mid-frame drops partial data.
        send_beats(2, 32'h11111111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_frames = 0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready),  32'd1);
        check("midrst_sum",   32'(out_sum),   32'd0);
        v = '{"post_reset", {4{32'h01010101}}, 0, 8'h10, 1'b1, 1'b0, 1'b0};
        do_frame(v);

        // Random frames against the arithmetic model, with random hold lengths.
        for (int r = 0; r < 40; r++) begin
            v.name = $sformatf("rand%0d", r);
            for (int b = 0; b < 4; b++) begin
                case ($urandom_range(0, 5))
                    0:       v.data[b*32 +: 32] = 32'hFFFFFFFF;
                    1:       v.data[b*32 +: 32] = 32'd0;
                    default: v.data[b*32 +: 32] = $urandom;
                endcase
            end
            v.hold = int'($urandom_range(0, 3));
            model(v.data, v.sum, v.o, v.a, v.x);
            do_frame(v);
        end

`ifdef PACKED_LANE_SUM_FRAMES_EN
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("frames_after_flush", 32'(out_frames), 32'(n_frames));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
